rr_burst_arbiter: RTL and testbench
===================================

Name: rr_burst_arbiter

Overview:
- Round-robin arbiter that shares one N-input decoupled sink between requesters, with burst lock.
- Each beat carries a `last` flag. Once a multi-beat burst starts, the grant holds to that input until its `last` beat fires.
- Drop-in sequential companion to the stdlib fixed-priority Arbiter: same io_in_*/io_out_*/io_chosen bundle, plus `last`, `locked` and a clock/reset.
- Used in front of shared output ports and memory request channels.

Parameters:
- N, 4, number of requesters (N >= 2); chosen width CW = ceil(log2(N)), 2 at default.
- W, 8, payload width of bits.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- io_in_i_valid  input  1  requester i has a beat (i = 0..N-1)
- io_in_i_bits  input  W  requester i payload
- io_in_i_last  input  1  beat is final of its burst (1 = single-beat transfer)
- io_in_i_ready  output  1  requester i beat accepted this cycle when valid
- io_out_ready  input  1  sink can accept
- io_out_valid  output  1  granted beat present
- io_out_bits  output  W  granted payload
- io_out_last  output  1  granted last flag
- io_chosen  output  CW  index of granted input
- io_locked  output  1  arbiter held mid-burst

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous, active-high. All state updates on the rising edge of clk.
- State registers:
  - last_grant [CW], reset N-1, so input 0 has first priority after reset.
  - lock, reset 0.
  - lock_idx [CW], reset 0.
- Outputs are combinational from state and inputs; there is no data register, so latency is 0 cycles in to out.
- Unlocked (lock=0):
  - chosen = first i with io_in_i_valid, searching last_grant+1, last_grant+2, ..., last_grant, with indices mod N.
  - If no input is valid: chosen = N-1 and io_out_valid = 0.
- Locked (lock=1):
  - chosen = lock_idx regardless of other valids.
  - io_out_valid = io_in_{lock_idx}_valid.
  - If that valid is low the output bubbles; other requesters are never served mid-burst.
- Output mux: io_out_bits, io_out_last and io_out_valid come from input `chosen` (valid per the rules above).
- Ready: io_in_i_ready = io_out_ready & (chosen == i). Every non-chosen ready is 0. Ready may depend combinationally on valids.
- fire = io_out_valid & io_out_ready.
- On fire:
  - last_grant <= chosen.
  - If io_out_last = 0: lock <= 1 and lock_idx <= chosen.
  - If io_out_last = 1: lock <= 0.
- No fire: all state holds, including when io_out_ready is low with valid high. The grant never changes while a beat is stalled in the locked state.
- Unlocked stall: chosen may change if valids change. Requesters must hold valid per the decoupled contract.
- io_locked = lock.
- Wrap-around: when last_grant = N-1, the search starts at index 0.
- Single-beat transfers (last=1) never set lock; pure round-robin results.
- Reset asserted mid-burst: lock=0 and last_grant=N-1 on the next edge; the partial burst is abandoned, with no flush or error flag.
- Reset has priority over fire in the same cycle.
- Valid held low on all inputs: no state change, io_out_valid=0.

Test Plan:
- Fairness: reset, then all four inputs valid with last=1, bits=0x10+i, io_out_ready=1 for 5 cycles -> io_chosen 0,1,2,3,0; io_out_bits 0x10,0x11,0x12,0x13,0x10; io_locked stays 0.
- Burst lock:
  - Stimulus: after reset only in2 valid with a 3-beat burst 0xA0,0xA1,0xA2 (last on 3rd); in0 raises valid at beat 2.
  - Required: io_chosen=2 for all 3 beats; io_in_0_ready=0 throughout; io_locked=1 after beat 1 and 0 after beat 3.
  - Next cycle io_chosen=0.
- Back-pressure: in1 valid with bits 0x55, io_out_ready=0 for 3 cycles -> io_out_valid=1, io_out_bits=0x55, io_in_1_ready=0, last_grant unchanged. Then ready=1 -> one fire, io_in_1_ready=1.
- Lock bubble:
  - Stimulus: locked on in3 after a first beat with last=0; in3 valid drops for 2 cycles while in0 is valid.
  - Required: io_out_valid=0, io_in_0_ready=0, io_locked=1, io_chosen=3.
  - in3 then returns with last=1 -> fires, lock releases, and in0 is granted the next cycle.
- Reset mid-burst: locked on in1, all inputs valid, assert reset 1 cycle -> io_locked=0 next cycle and io_chosen=0.
- Idle: no valids for 4 cycles -> io_out_valid=0, io_chosen=N-1, io_in_3_ready=io_out_ready, state unchanged (next grant order identical to before idle).

Source files
------------

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter over four decoupled requesters with burst lock.
// A multi-beat burst keeps the grant until its last beat is accepted.
module rr_burst_arbiter #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          io_in_0_valid,
    input  logic [W-1:0]  io_in_0_bits,
    input  logic          io_in_0_last,
    output logic          io_in_0_ready,
    input  logic          io_in_1_valid,
    input  logic [W-1:0]  io_in_1_bits,
    input  logic          io_in_1_last,
    output logic          io_in_1_ready,
    input  logic          io_in_2_valid,
    input  logic [W-1:0]  io_in_2_bits,
    input  logic          io_in_2_last,
    output logic          io_in_2_ready,
    input  logic          io_in_3_valid,
    input  logic [W-1:0]  io_in_3_bits,
    input  logic          io_in_3_last,
    output logic          io_in_3_ready,
    input  logic          io_out_ready,
    output logic          io_out_valid,
    output logic [W-1:0]  io_out_bits,
    output logic          io_out_last,
    output logic [CW-1:0] io_chosen,
    output logic          io_locked
);

    // The port list names four requesters, so only N = 4 is meaningful.
    if (N != 4) begin : g_bad_n
        $error("rr_burst_arbiter: N must be 4");
    end

    logic [N-1:0]  w_valid;
    logic [N-1:0]  w_last;
    logic [W-1:0]  w_bits [N];

    logic [CW-1:0] r_last_grant;
    logic          r_lock;
    logic [CW-1:0] r_lock_idx;

    logic [CW-1:0] w_last_grant_nxt;
    logic          w_lock_nxt;
    logic [CW-1:0] w_lock_idx_nxt;

    logic [CW-1:0] w_rr_idx;
    logic          w_rr_found;
    int            w_cand;
    logic [CW-1:0] w_chosen;
    logic          w_out_valid;
    logic          w_out_last;
    logic          w_fire;

    assign w_valid = {io_in_3_valid, io_in_2_valid,
                      io_in_1_valid, io_in_0_valid};
    assign w_last  = {io_in_3_last, io_in_2_last,
                      io_in_1_last, io_in_0_last};

    assign w_bits[0] = io_in_0_bits;
    assign w_bits[1] = io_in_1_bits;
    assign w_bits[2] = io_in_2_bits;
    assign w_bits[3] = io_in_3_bits;

    // Search starts just past the previous grant; idle falls back to N-1.
    always_comb begin
        w_rr_idx   = CW'(N - 1);
        w_rr_found = 1'b0;
        w_cand     = 0;
        for (int k = 1; k <= N; k++) begin
            w_cand = (int'(r_last_grant) + k) % N;
            if (!w_rr_found && w_valid[CW'(w_cand)]) begin
                w_rr_idx   = CW'(w_cand);
                w_rr_found = 1'b1;
            end
        end
    end

    assign w_chosen    = r_lock ? r_lock_idx : w_rr_idx;
    assign w_out_valid = w_valid[w_chosen];
    assign w_out_last  = w_last[w_chosen];
    assign w_fire      = w_out_valid & io_out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= CW'(N - 1);
            r_lock       <= 1'b0;
            r_lock_idx   <= '0;
        end else begin
            r_last_grant <= w_last_grant_nxt;
            r_lock       <= w_lock_nxt;
            r_lock_idx   <= w_lock_idx_nxt;
        end
    end

    always_comb begin
        w_last_grant_nxt = r_last_grant;
        w_lock_nxt       = r_lock;
        w_lock_idx_nxt   = r_lock_idx;
        if (w_fire) begin
            w_last_grant_nxt = w_chosen;
            w_lock_nxt       = ~w_out_last;
            if (!w_out_last) begin
                w_lock_idx_nxt = w_chosen;
            end
        end
    end

    always_comb begin
        io_out_valid  = w_out_valid;
        io_out_bits   = w_bits[w_chosen];
        io_out_last   = w_out_last;
        io_chosen     = w_chosen;
        io_locked     = r_lock;
        io_in_0_ready = io_out_ready & (w_chosen == CW'(0));
        io_in_1_ready = io_out_ready & (w_chosen == CW'(1));
        io_in_2_ready = io_out_ready & (w_chosen == CW'(2));
        io_in_3_ready = io_out_ready & (w_chosen == CW'(3));
    end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Bench for rr_burst_arbiter: directed plan sequences plus random traffic,
// predicted by a queue-based priority model and checked by a monitor.
module tb_rr_burst_arbiter;

    typedef struct packed {
        logic       ov;
        logic [7:0] ob;
        logic       ol;
        logic [1:0] ch;
        logic       lk;
        logic [3:0] ir;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  s_v;
    logic [3:0]  s_l;
    logic [31:0] s_b;
    logic        s_rdy;

    logic [3:0]  a_ir;
    logic        a_ov;
    logic [7:0]  a_ob;
    logic        a_ol;
    logic [1:0]  a_ch;
    logic        a_lk;

    exp_t        sb [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    int          m_last;
    bit          m_lock;
    int          m_lidx;
    bit          m_known = 0;

    always #5 clk = ~clk;

    rr_burst_arbiter #(.N(4), .W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .io_in_0_valid (s_v[0]),
        .io_in_0_bits  (s_b[7:0]),
        .io_in_0_last  (s_l[0]),
        .io_in_0_ready (a_ir[0]),
        .io_in_1_valid (s_v[1]),
        .io_in_1_bits  (s_b[15:8]),
        .io_in_1_last  (s_l[1]),
        .io_in_1_ready (a_ir[1]),
        .io_in_2_valid (s_v[2]),
        .io_in_2_bits  (s_b[23:16]),
        .io_in_2_last  (s_l[2]),
        .io_in_2_ready (a_ir[2]),
        .io_in_3_valid (s_v[3]),
        .io_in_3_bits  (s_b[31:24]),
        .io_in_3_last  (s_l[3]),
        .io_in_3_ready (a_ir[3]),
        .io_out_ready  (s_rdy),
        .io_out_valid  (a_ov),
        .io_out_bits   (a_ob),
        .io_out_last   (a_ol),
        .io_chosen     (a_ch),
        .io_locked     (a_lk)
    );

    function automatic exp_t predict(input logic [3:0] v,
                                     input logic [3:0] l,
                                     input logic [31:0] b,
                                     input logic rdy);
        exp_t e;
        int   order [$];
        int   ch;
        ch = 3;
        if (m_lock) begin
            ch = m_lidx;
        end else begin
            // Priority list: everyone after the last winner, winner last.
            for (int k = 1; k <= 4; k++) order.push_back((m_last + k) % 4);
            foreach (order[j]) begin
                if (v[order[j]]) begin
                    ch = order[j];
                    break;
                end
            end
        end
        e.ch = 2'(ch);
        e.ov = v[ch];
        e.ob = b[8*ch +: 8];
        e.ol = l[ch];
        e.lk = m_lock;
        e.ir = rdy ? 4'(1 << ch) : 4'b0;
        return e;
    endfunction

    task automatic cycle(input logic [3:0] v, input logic [3:0] l,
                         input logic [31:0] b, input logic rdy,
                         input logic rst);
        exp_t e;
        s_v = v; s_l = l; s_b = b; s_rdy = rdy; reset = rst;
        e = predict(v, l, b, rdy);
        if (m_known) sb.push_back(e);
        @(posedge clk);
        if (rst) begin
            m_last = 3; m_lock = 0; m_lidx = 0; m_known = 1;
        end else if (m_known && e.ov && rdy) begin
            m_last = e.ch;
            if (!e.ol) begin
                m_lock = 1; m_lidx = e.ch;
            end else begin
                m_lock = 0;
            end
        end
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            a = '{ov: a_ov, ob: a_ob, ol: a_ol, ch: a_ch, lk: a_lk, ir: a_ir};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs t=%0t got v=%b b=%h l=%b ch=%0d lk=%b rdy=%b need v=%b b=%h l=%b ch=%0d lk=%b rdy=%b",
                         $time, a.ov, a.ob, a.ol, a.ch, a.lk, a.ir,
                         e.ov, e.ob, e.ol, e.ch, e.lk, e.ir);
            end
        end
    end

    initial begin
        s_v = 0; s_l = 0; s_b = 0; s_rdy = 0; reset = 1;
        @(posedge clk); #1;
        cycle(4'h0, 4'h0, 32'h0, 1'b1, 1'b1);

        // Fairness: all valid, single beats.
        repeat (5) cycle(4'hF, 4'hF, 32'h13121110, 1'b1, 1'b0);
        cycle(4'h0, 4'h0, 32'h0, 1'b1, 1'b1);

        // Burst on in2 with in0 joining at beat 2.
        cycle(4'h4, 4'h0, 32'h00A00000, 1'b1, 1'b0);
        cycle(4'h5, 4'h0, 32'h00A10001, 1'b1, 1'b0);
        cycle(4'h5, 4'h4, 32'h00A20001, 1'b1, 1'b0);
        cycle(4'h1, 4'h1, 32'h00000001, 1'b1, 1'b0);

        // Back-pressure on in1.
        repeat (3) cycle(4'h2, 4'h2, 32'h00005500, 1'b0, 1'b0);
        cycle(4'h2, 4'h2, 32'h00005500, 1'b1, 1'b0);

        // Lock bubble on in3 while in0 waits.
        cycle(4'h0, 4'h0, 32'h0, 1'b1, 1'b1);
        cycle(4'h8, 4'h0, 32'h30000000, 1'b1, 1'b0);
        repeat (2) cycle(4'h1, 4'h1, 32'h00000007, 1'b1, 1'b0);
        cycle(4'h9, 4'hF, 32'h31000007, 1'b1, 1'b0);
        cycle(4'h1, 4'h1, 32'h00000007, 1'b1, 1'b0);

        // Reset in the middle of a burst on in1.
        cycle(4'h2, 4'h0, 32'h00004400, 1'b1, 1'b0);
        cycle(4'hF, 4'h0, 32'h44444444, 1'b1, 1'b1);
        cycle(4'hF, 4'hF, 32'h44444444, 1'b0, 1'b0);

        // Idle with ready toggling, then full round again.
        cycle(4'h0, 4'h0, 32'h0, 1'b1, 1'b0);
        cycle(4'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        cycle(4'h0, 4'h0, 32'h0, 1'b1, 1'b0);
        cycle(4'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        repeat (4) cycle(4'hF, 4'hF, 32'h23222120, 1'b1, 1'b0);

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            cycle(4'($urandom), 4'($urandom | $urandom), $urandom,
                  1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 99) == 0));
        end

        s_v = 0; reset = 0;
        @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain left=%0d need 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
